// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Purpose : bundles the fetch2 push handshake and the decode-side head view of
//           the fetch queue into one interface.
// Signals :
//   push_valid / push_ready : fetch2 packet handshake
//   push_pc                 : PC of inst0 (push_data[63:32]); inst1 PC is +4
//   push_data               : [63:32] = inst0, [31:0] = inst1
//   push_mask               : bit0 = inst0 valid, bit1 = inst1 valid
//   inst0/pc0/valid0        : oldest pending instruction
//   inst1/pc1/valid1        : next instruction from the same packet
//   pop                     : instructions consumed this cycle (0, 1 or 2)
//   count                   : occupied packet entries
// Modports: master = fetch2/decode side, slave = the queue itself.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int PTR_W = $clog2(DEPTH);

  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_pc;
  logic [63:0]      push_data;
  logic [1:0]       push_mask;
  logic [31:0]      inst0;
  logic [31:0]      inst1;
  logic [31:0]      pc0;
  logic [31:0]      pc1;
  logic             valid0;
  logic             valid1;
  logic [1:0]       pop;
  logic [PTR_W:0]   count;

  modport master (
    output push_valid, push_pc, push_data, push_mask, pop,
    input  push_ready, inst0, inst1, pc0, pc1, valid0, valid1, count
  );

  modport slave (
    input  push_valid, push_pc, push_data, push_mask, pop,
    output push_ready, inst0, inst1, pc0, pc1, valid0, valid1, count
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Purpose : dual-slot instruction buffer between imem fetch (fetch2) and
//           decode. Holds DEPTH fetch packets {pc, 64-bit data, 2-bit mask}
//           so a decode stall does not stall the imem read. Decode may take
//           0, 1 or 2 instructions per cycle; a half-consumed packet stays at
//           the head with its remaining instruction shifted into slot 0.
// Ports   :
//   clock_i  : core clock
//   resetn_i : asynchronous active-low reset
//   flush_i  : synchronous clear (redirect / trap), beats push and pop
//   fq       : fetch_queue_if.slave (push handshake, head view, pop, count)
// Options : define FETCH_QUEUE_BYPASS_EN to drive the head view straight from
//           the push inputs when the queue is empty (zero-latency path).
// -----------------------------------------------------------------------------

`ifndef SYNTHESIS
// Simulation-only checker: decode must never pop more than it is shown.
module fetch_queue_chk (
  input logic       clock_i,
  input logic       resetn_i,
  input logic       flush_i,
  input logic [1:0] pop_i,
  input logic [1:0] nvalid_i
);
  // Report over-pops; the queue itself clamps them.
  always @(posedge clock_i) begin
    if (resetn_i && !flush_i) begin
      assert (pop_i <= nvalid_i)
        else $error("fetch_queue: pop %0d exceeds %0d valid slots", pop_i, nvalid_i);
    end
  end
endmodule
`endif

module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic          clock_i,
  input logic          resetn_i,
  input logic          flush_i,
  fetch_queue_if.slave fq
);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Packet storage and pointers
  logic [31:0]      r_pc   [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [1:0]       r_mask [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic        w_empty;
  logic        w_ready;
  logic        w_push_ok;
  logic        w_bypass;
  logic [31:0] w_src_pc;
  logic [63:0] w_src_data;
  logic [1:0]  w_src_mask;
  logic [31:0] w_inst0;
  logic [31:0] w_inst1;
  logic [31:0] w_pc0;
  logic [31:0] w_pc1;
  logic        w_valid0;
  logic        w_valid1;
  logic [1:0]  w_nvalid;
  logic [1:0]  w_pop_eff;
  logic        w_retire;
  logic        w_partial;
  logic        w_wr_en;
  logic [1:0]  w_wr_mask;
  logic        w_inc;
  logic        w_head_retire;
  logic        w_head_partial;

  assign w_empty   = (r_count == {(PTR_W+1){1'b0}});
  // Ready ignores pop on purpose: a full queue refuses even if it drains now.
  assign w_ready   = (r_count != FULL_CNT);
  assign w_push_ok = fq.push_valid && w_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Gated by reset so the view stays invalid while resetn_i is low.
  assign w_bypass = resetn_i && w_empty && fq.push_valid && (fq.push_mask != 2'b00);
`else
  assign w_bypass = 1'b0;
`endif

  // Pick the packet the head view is built from: bypassed push, head entry, or nothing.
  always_comb begin
    w_src_pc   = 32'h0;
    w_src_data = 64'h0;
    w_src_mask = 2'b00;
    if (w_bypass) begin
      w_src_pc   = fq.push_pc;
      w_src_data = fq.push_data;
      w_src_mask = fq.push_mask;
    end else if (!w_empty) begin
      w_src_pc   = r_pc[r_head];
      w_src_data = r_data[r_head];
      w_src_mask = r_mask[r_head];
    end else begin
      w_src_mask = 2'b00;
    end
  end

  // Decode the source packet into the two output slots, shifting a lone slot1 down.
  always_comb begin
    w_inst0  = 32'h0;
    w_inst1  = 32'h0;
    w_pc0    = 32'h0;
    w_pc1    = 32'h0;
    w_valid0 = 1'b0;
    w_valid1 = 1'b0;
    w_nvalid = 2'd0;
    case (w_src_mask)
      2'b11: begin
        w_inst0  = w_src_data[63:32];
        w_pc0    = w_src_pc;
        w_inst1  = w_src_data[31:0];
        w_pc1    = w_src_pc + 32'd4;
        w_valid0 = 1'b1;
        w_valid1 = 1'b1;
        w_nvalid = 2'd2;
      end
      2'b01: begin
        w_inst0  = w_src_data[63:32];
        w_pc0    = w_src_pc;
        w_valid0 = 1'b1;
        w_nvalid = 2'd1;
      end
      2'b10: begin
        w_inst0  = w_src_data[31:0];
        w_pc0    = w_src_pc + 32'd4;
        w_valid0 = 1'b1;
        w_nvalid = 2'd1;
      end
      default: begin
        w_nvalid = 2'd0;
      end
    endcase
  end

  // Clamp the pop to what is shown and classify it as a retire or a half-consume.
  always_comb begin
    if (fq.pop > w_nvalid) begin
      w_pop_eff = w_nvalid;
    end else begin
      w_pop_eff = fq.pop;
    end
    w_retire  = (w_pop_eff != 2'd0) && (w_pop_eff == w_nvalid);
    w_partial = (w_nvalid == 2'd2) && (w_pop_eff == 2'd1);
  end

  // Work out what gets written at tail and what happens to the head entry.
  always_comb begin
    w_wr_mask      = fq.push_mask;
    w_wr_en        = 1'b0;
    w_inc          = 1'b0;
    w_head_retire  = 1'b0;
    w_head_partial = 1'b0;
    if (w_bypass) begin
      // Consumption applies to the pushed packet; store only the leftover.
      w_wr_en = !w_retire;
      w_inc   = !w_retire;
      if (w_partial) begin
        w_wr_mask = 2'b10;
      end else begin
        w_wr_mask = fq.push_mask;
      end
    end else begin
      // An all-empty mask is accepted but never stored.
      w_wr_en        = w_push_ok && (fq.push_mask != 2'b00);
      w_inc          = w_wr_en;
      w_head_retire  = w_retire;
      w_head_partial = w_partial;
    end
  end

  // Queue state: async reset, flush clears like reset, else push/pop update.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= 32'h0;
        r_data[i] <= 64'h0;
        r_mask[i] <= 2'b00;
      end
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= 32'h0;
        r_data[i] <= 64'h0;
        r_mask[i] <= 2'b00;
      end
    end else begin
      if (w_wr_en) begin
        r_pc[r_tail]   <= fq.push_pc;
        r_data[r_tail] <= fq.push_data;
        r_mask[r_tail] <= w_wr_mask;
        r_tail         <= r_tail + PTR_ONE;
      end
      // Head and tail never alias here: a write while non-empty implies not full.
      if (w_head_retire) begin
        r_mask[r_head] <= 2'b00;
        r_head         <= r_head + PTR_ONE;
      end else if (w_head_partial) begin
        r_mask[r_head] <= 2'b10;
      end
      r_count <= r_count + (PTR_W+1)'(w_inc) - (PTR_W+1)'(w_head_retire);
    end
  end

  assign fq.push_ready = w_ready;
  assign fq.count      = r_count;
  assign fq.inst0      = w_inst0;
  assign fq.inst1      = w_inst1;
  assign fq.pc0        = w_pc0;
  assign fq.pc1        = w_pc1;
  assign fq.valid0     = w_valid0;
  assign fq.valid1     = w_valid1;

`ifndef SYNTHESIS
  fetch_queue_chk u_chk (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .flush_i  (flush_i),
    .pop_i    (fq.pop),
    .nvalid_i (w_nvalid)
  );
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Purpose : directed self-checking bench for fetch_queue (DEPTH=4). Inputs
//           change 1 time unit after a rising edge and outputs are checked
//           1 unit later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   n_run  = 0;
  int   n_fail = 0;

  fetch_queue_if #(.DEPTH(4)) fq ();

  fetch_queue #(.DEPTH(4)) dut (
    .clock_i  (clk),
    .resetn_i (resetn),
    .flush_i  (flush),
    .fq       (fq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i0(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic logic [31:0] i1(input logic [31:0] pc);
    return 32'hB000_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] mask);
    fq.push_valid = 1'b1;
    fq.push_pc    = pc;
    fq.push_data  = {i0(pc), i1(pc)};
    fq.push_mask  = mask;
  endtask

  task automatic nopush();
    fq.push_valid = 1'b0;
    fq.push_pc    = 32'h0;
    fq.push_data  = 64'h0;
    fq.push_mask  = 2'b00;
  endtask

  initial begin
    resetn = 1'b1;
    flush  = 1'b0;
    fq.pop = 2'd0;
    nopush();
    #1 resetn = 1'b0;
    #1;
    chk("rst_count",  fq.count,      64'd0);
    chk("rst_valid0", fq.valid0,     64'd0);
    chk("rst_valid1", fq.valid1,     64'd0);
    chk("rst_ready",  fq.push_ready, 64'd1);
    chk("rst_inst0",  fq.inst0,      64'd0);
    chk("rst_pc0",    fq.pc0,        64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Fill to DEPTH, one packet per cycle
    push(32'h100, 2'b11);
    #1 chk("fill_ready_empty", fq.push_ready, 64'd1);
    tick();
    nopush();
    #1;
    chk("fill1_count",  fq.count,  64'd1);
    chk("fill1_valid0", fq.valid0, 64'd1);
    chk("fill1_valid1", fq.valid1, 64'd1);
    chk("fill1_pc0",    fq.pc0,    64'h100);
    chk("fill1_pc1",    fq.pc1,    64'h104);
    chk("fill1_inst0",  fq.inst0,  64'(i0(32'h100)));
    chk("fill1_inst1",  fq.inst1,  64'(i1(32'h100)));
    for (int k = 1; k < 4; k++) begin
      push(32'h100 + 32'(8 * k), 2'b11);
      tick();
    end
    nopush();
    #1;
    chk("full_count", fq.count,      64'd4);
    chk("full_ready", fq.push_ready, 64'd0);
    push(32'h120, 2'b11);
    #1 chk("push5_ready", fq.push_ready, 64'd0);
    tick();
    nopush();
    #1;
    chk("push5_count", fq.count, 64'd4);
    chk("push5_pc0",   fq.pc0,   64'h100);
    chk("push5_pc1",   fq.pc1,   64'h104);

    // Full queue refuses a push even with a same-cycle pop
    push(32'h120, 2'b11);
    fq.pop = 2'd2;
    #1 chk("fullpop_ready", fq.push_ready, 64'd0);
    tick();
    nopush();
    fq.pop = 2'd0;
    #1;
    chk("fullpop_count", fq.count, 64'd3);
    chk("fullpop_pc0",   fq.pc0,   64'h108);
    for (int k = 0; k < 3; k++) begin
      fq.pop = 2'd2;
      #1 chk("drain_pc0", fq.pc0, 64'(32'h108 + 32'(8 * k)));
      tick();
    end
    fq.pop = 2'd0;
    #1;
    chk("drain_count",  fq.count,  64'd0);
    chk("drain_valid0", fq.valid0, 64'd0);

    // Partial pop of a two-instruction packet
    push(32'h200, 2'b11);
    tick();
    nopush();
    fq.pop = 2'd1;
    #1 chk("part_pc0_before", fq.pc0, 64'h200);
    tick();
    fq.pop = 2'd0;
    #1;
    chk("part_inst0",  fq.inst0,  64'(i1(32'h200)));
    chk("part_pc0",    fq.pc0,    64'h204);
    chk("part_valid0", fq.valid0, 64'd1);
    chk("part_valid1", fq.valid1, 64'd0);
    chk("part_inst1",  fq.inst1,  64'd0);
    chk("part_pc1",    fq.pc1,    64'd0);
    chk("part_count",  fq.count,  64'd1);
    fq.pop = 2'd1;
    tick();
    fq.pop = 2'd0;
    #1;
    chk("part_retire_count",  fq.count,  64'd0);
    chk("part_retire_valid0", fq.valid0, 64'd0);

    // Masked pushes: slot1-only, empty mask, slot0-only
    push(32'h300, 2'b10);
    tick();
    nopush();
    #1;
    chk("m10_inst0",  fq.inst0,  64'(i1(32'h300)));
    chk("m10_pc0",    fq.pc0,    64'h304);
    chk("m10_valid1", fq.valid1, 64'd0);
    chk("m10_count",  fq.count,  64'd1);
    push(32'h308, 2'b00);
    #1 chk("m00_ready", fq.push_ready, 64'd1);
    tick();
    nopush();
    #1 chk("m00_count", fq.count, 64'd1);
    push(32'h310, 2'b01);
    tick();
    nopush();
    #1 chk("m01_count", fq.count, 64'd2);
    fq.pop = 2'd1;
    tick();
    fq.pop = 2'd0;
    #1;
    chk("m01_pc0",    fq.pc0,    64'h310);
    chk("m01_inst0",  fq.inst0,  64'(i0(32'h310)));
    chk("m01_valid1", fq.valid1, 64'd0);
    chk("m01_count",  fq.count,  64'd1);

    // Simultaneous push and retire; tail wraps to 0 here
    push(32'h318, 2'b11);
    fq.pop = 2'd1;
    tick();
    nopush();
    fq.pop = 2'd0;
    #1;
    chk("pp_count",  fq.count,  64'd1);
    chk("pp_pc0",    fq.pc0,    64'h318);
    chk("pp_pc1",    fq.pc1,    64'h31C);
    chk("pp_valid1", fq.valid1, 64'd1);

    // Flush beats a same-cycle push and pop
    push(32'h320, 2'b11);
    tick();
    nopush();
    #1 chk("fl_pre_count", fq.count, 64'd2);
    flush = 1'b1;
    push(32'h328, 2'b11);
    fq.pop = 2'd2;
    tick();
    flush = 1'b0;
    nopush();
    fq.pop = 2'd0;
    #1;
    chk("fl_count",  fq.count,  64'd0);
    chk("fl_valid0", fq.valid0, 64'd0);
    tick();
    chk("fl_count_later", fq.count, 64'd0);

    // Asynchronous reset mid-traffic with three entries held
    for (int k = 0; k < 3; k++) begin
      push(32'h330 + 32'(8 * k), 2'b11);
      tick();
    end
    nopush();
    #1 chk("ar_pre_count", fq.count, 64'd3);
    push(32'h348, 2'b11);
    resetn = 1'b0;
    #1;
    chk("ar_count",  fq.count,      64'd0);
    chk("ar_valid0", fq.valid0,     64'd0);
    chk("ar_ready",  fq.push_ready, 64'd1);
    tick();
    nopush();
    resetn = 1'b1;
    tick();

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass: empty queue, packet consumed in the cycle it is pushed
    push(32'h400, 2'b11);
    fq.pop = 2'd2;
    #1;
    chk("byp_valid0", fq.valid0, 64'd1);
    chk("byp_valid1", fq.valid1, 64'd1);
    chk("byp_pc0",    fq.pc0,    64'h400);
    chk("byp_pc1",    fq.pc1,    64'h404);
    chk("byp_inst0",  fq.inst0,  64'(i0(32'h400)));
    tick();
    nopush();
    fq.pop = 2'd0;
    #1;
    chk("byp_count",  fq.count,  64'd0);
    chk("byp_after",  fq.valid0, 64'd0);
`else
    // No bypass: packet shows up one cycle after acceptance
    push(32'h400, 2'b11);
    #1;
    chk("lat_valid0_same", fq.valid0, 64'd0);
    chk("lat_count_same",  fq.count,  64'd0);
    tick();
    nopush();
    #1;
    chk("lat_valid0_next", fq.valid0, 64'd1);
    chk("lat_pc0_next",    fq.pc0,    64'h400);
    chk("lat_count_next",  fq.count,  64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
